// File: rtl/byte_port_word_master.sv
// Word load/store initiator over a byte-wide synchronous RAM port.
// Stores issue only the enabled lanes; loads issue all four lanes and reassemble a little-endian word.
module byte_port_word_master #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-3:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_DRAIN,
    RESP
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-3:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        mask_reg;
  logic [1:0]        lane_reg;
  logic [23:0]       rbuf_reg;
  logic [31:0]       resp_rdata_reg;

  // Read tag pipeline: one stage per cycle of RAM read latency.
  logic              pipe_vld_reg  [RD_LAT];
  logic [1:0]        pipe_lane_reg [RD_LAT];
  logic              pipe_vld_next [RD_LAT];
  logic [1:0]        pipe_lane_next[RD_LAT];

  logic       accept;
  logic       issue_rd;
  logic [1:0] wr_lane;
  logic [3:0] mask_after;
  logic       cap_vld;
  logic [1:0] cap_lane;
  logic       cap_last;

  // Lowest still-pending store lane.
  always_comb begin
    wr_lane = 2'd3;
    if (mask_reg[0])      wr_lane = 2'd0;
    else if (mask_reg[1]) wr_lane = 2'd1;
    else if (mask_reg[2]) wr_lane = 2'd2;
  end

  assign mask_after = mask_reg & ~(4'b0001 << wr_lane);
  assign issue_rd   = (state_reg == READ_ISSUE);
  assign cap_vld    = pipe_vld_reg[RD_LAT-1];
  assign cap_lane   = pipe_lane_reg[RD_LAT-1];
  assign cap_last   = cap_vld && (cap_lane == 2'd3);

  assign pipe_vld_next[0]  = issue_rd;
  assign pipe_lane_next[0] = lane_reg;

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      assign pipe_vld_next[gi]  = pipe_vld_reg[gi-1];
      assign pipe_lane_next[gi] = pipe_lane_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_we)                state_next = READ_ISSUE;
          else if (req_wstrb == 4'b0) state_next = RESP;
          else                        state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_reg, wr_lane};
        mem_wdata = wdata_reg[{wr_lane, 3'b000} +: 8];
        if (mask_after == 4'b0) state_next = RESP;
      end
      READ_ISSUE: begin
        mem_addr = {addr_reg, lane_reg};
        if (lane_reg == 2'd3) state_next = READ_DRAIN;
      end
      READ_DRAIN: begin
        if (cap_last) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
      lane_reg       <= '0;
      rbuf_reg       <= '0;
      resp_rdata_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        mask_reg  <= req_we ? req_wstrb : 4'b0;
        lane_reg  <= 2'd0;
      end
      if (state_reg == WRITE) mask_reg <= mask_after;
      if (issue_rd)           lane_reg <= lane_reg + 2'd1;
      // Lane 3 bypasses the buffer and goes straight into the response word.
      if (cap_vld && (cap_lane != 2'd3)) rbuf_reg[{cap_lane, 3'b000} +: 8] <= mem_rdata;
      if (state_next == RESP && state_reg != RESP) begin
        if (state_reg == READ_DRAIN) resp_rdata_reg <= {mem_rdata, rbuf_reg};
        else                         resp_rdata_reg <= 32'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (RST) begin
        pipe_vld_reg[i]  <= 1'b0;
        pipe_lane_reg[i] <= 2'd0;
      end else begin
        pipe_vld_reg[i]  <= pipe_vld_next[i];
        pipe_lane_reg[i] <= pipe_lane_next[i];
      end
    end
  end

  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_byte_port_word_master.sv
// Directed bench for byte_port_word_master: byte RAM environment, schedule-based reference model
// compared every cycle, plus literal latency/data expectations per transaction.
module tb_byte_port_word_master;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 2;
  localparam int NCYC   = 3000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-3:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_wstrb = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  byte_port_word_master #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Byte RAM environment: read data appears RD_LAT cycles after its address.
  logic [7:0] ram [512];
  logic [8:0] apipe [RD_LAT];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    apipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rdata = ram[apipe[RD_LAT-1]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: per-cycle expected outputs derived from the timing rules.
  logic        e_we [NCYC];
  logic [8:0]  e_addr [NCYC];
  logic [7:0]  e_wd [NCYC];
  logic        e_rv [NCYC];
  logic [31:0] e_rd [NCYC];
  logic [7:0]  mref [512];
  int          busy_end = 0;
  logic [31:0] hold = '0;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]  = i[7:0];
      mref[i] = i[7:0];
    end
    for (int i = 0; i < NCYC; i++) begin
      e_we[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0; e_rv[i] = 1'b0; e_rd[i] = '0;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      for (int i = cyc + 1; i < NCYC; i++) begin
        e_we[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0; e_rv[i] = 1'b0; e_rd[i] = '0;
      end
      busy_end = cyc;
      hold = '0;
    end else if (cyc < NCYC - 20) begin
      logic exp_ready;
      exp_ready = (cyc > busy_end);
      if (e_rv[cyc]) hold = e_rd[cyc];
      chk("req_ready",  {31'd0, req_ready},  {31'd0, exp_ready});
      chk("mem_we",     {31'd0, mem_we},     {31'd0, e_we[cyc]});
      chk("mem_addr",   {23'd0, mem_addr},   {23'd0, e_addr[cyc]});
      chk("mem_wdata",  {24'd0, mem_wdata},  {24'd0, e_wd[cyc]});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_rv[cyc]});
      chk("resp_rdata", resp_rdata, hold);
      if (req_valid && exp_ready) begin
        if (req_we) begin
          int k;
          k = 0;
          for (int l = 0; l < 4; l++) begin
            if (req_wstrb[l]) begin
              k++;
              e_we[cyc+k]   = 1'b1;
              e_addr[cyc+k] = {req_addr, l[1:0]};
              e_wd[cyc+k]   = req_wdata[8*l +: 8];
              mref[{req_addr, l[1:0]}] = req_wdata[8*l +: 8];
            end
          end
          e_rv[cyc+k+1] = 1'b1;
          e_rd[cyc+k+1] = 32'd0;
          busy_end = cyc + k + 1;
        end else begin
          logic [31:0] w;
          for (int l = 0; l < 4; l++) begin
            e_addr[cyc+1+l] = {req_addr, l[1:0]};
            w[8*l +: 8] = mref[{req_addr, l[1:0]}];
          end
          e_rv[cyc+5+RD_LAT] = 1'b1;
          e_rd[cyc+5+RD_LAT] = w;
          busy_end = cyc + 5 + RD_LAT;
        end
      end
    end
  end

  // Called aligned to 1 time unit after a rising edge; returns likewise.
  task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit keep, output int t_acc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    t_acc = -1;
    for (int i = 0; i < 40 && t_acc < 0; i++) begin
      @(negedge CLK);
      if (req_ready) t_acc = cyc;
    end
    if (t_acc < 0) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge CLK); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int t_acc, output int lat, output logic [31:0] data);
    lat = -1; data = '0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (i > 0 || t_acc < cyc) begin
        @(negedge CLK);
        if (resp_valid) begin lat = cyc - t_acc; data = resp_rdata; end
      end
    end
    if (lat < 0) chk("resp_timeout", 32'd1, 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic op(input string name, input logic we, input logic [6:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int exp_lat, input logic [31:0] exp_data);
    int t, lat;
    logic [31:0] data;
    send(we, a, d, s, 1'b0, t);
    wait_resp(t, lat, data);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_data"}, data, exp_data);
    $display("txn %s we=%0b addr=%h wdata=%h wstrb=%b acc=%0d lat=%0d rdata=%h",
             name, we, a, d, s, t, lat, data);
  endtask

  initial begin
    int t1, t2, lat, cnt;
    logic [31:0] data;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    op("st_full",   1'b1, 7'h05, 32'hA1B2C3D4, 4'b1111, 5, 32'h0);
    op("ld_full",   1'b0, 7'h05, 32'h0,        4'b0000, 5 + RD_LAT, 32'hA1B2C3D4);
    op("st_1010",   1'b1, 7'h7F, 32'h11223344, 4'b1010, 3, 32'h0);
    op("ld_wrap",   1'b0, 7'h7F, 32'h0,        4'b0000, 5 + RD_LAT, 32'h11FE33FC);
    op("st_none",   1'b1, 7'h10, 32'hFFFFFFFF, 4'b0000, 1, 32'h0);
    op("ld_none",   1'b0, 7'h10, 32'h0,        4'b1111, 5 + RD_LAT, 32'h43424140);
    op("st_0110",   1'b1, 7'h22, 32'hDEADBEEF, 4'b0110, 3, 32'h0);
    op("ld_0110",   1'b0, 7'h22, 32'h0,        4'b0000, 5 + RD_LAT, 32'h8BADBE88);

    // Abort a load with reset at T+2.
    send(1'b0, 7'h05, 32'h0, 4'b0, 1'b0, t1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (resp_valid) cnt++;
    end
    chk("abort_no_resp", cnt, 0);
    $display("txn abort load acc=%0d resp_after_reset=%0d", t1, cnt);
    @(posedge CLK); #1;
    op("ld_after_rst", 1'b0, 7'h05, 32'h0, 4'b0000, 5 + RD_LAT, 32'hA1B2C3D4);

    // Back-to-back loads with req_valid held high.
    send(1'b0, 7'h7F, 32'h0, 4'b0, 1'b1, t1);
    send(1'b0, 7'h22, 32'h0, 4'b0, 1'b0, t2);
    chk("b2b_gap", t2 - t1, 6 + RD_LAT);
    wait_resp(t2, lat, data);
    chk("b2b_lat", lat, 5 + RD_LAT);
    chk("b2b_data", data, 32'h8BADBE88);
    $display("txn b2b acc1=%0d acc2=%0d lat=%0d rdata=%h", t1, t2, lat, data);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/byte_port_word_master.md
Name: byte_port_word_master

Overview:
- Initiator that serves 32-bit word load/store requests from a core-side request port using a byte-wide synchronous RAM port (WE0/A0/Di0/Do0 style, one byte per access).
- Splits each word access into sequential byte accesses and reassembles read bytes into a little-endian word.
- Sits between the core/peripheral bus and the byte-wide 128-word scratch RAM.

Parameters:
- ADDR_W, 9, byte address width on the memory side; word address width is ADDR_W-2.
- RD_LAT, 2, cycles from a byte address being driven on mem_addr to its data being valid on mem_rdata (input register plus RAM output); legal range 1..4.

Ports:
- CLK  input  1  clock, all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W-2  word address.
- req_wdata  input  32  store data, byte k = bits [8k+7:8k].
- req_wstrb  input  4  store byte enables; ignored for loads.
- resp_valid  output  1  one-cycle completion pulse, no backpressure.
- resp_rdata  output  32  load data, valid with resp_valid; 0 for stores.
- mem_we  output  1  byte write enable.
- mem_addr  output  ADDR_W  byte address = {word address, lane[1:0]}.
- mem_wdata  output  8  byte write data.
- mem_rdata  input  8  byte read data, RD_LAT cycles after its address.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, internal counters and byte buffer cleared. Reset in any state aborts the operation; no response is produced for the aborted request.
- States: IDLE, WRITE, READ_ISSUE, READ_DRAIN, RESP.
- Handshake:
  - A request is accepted in cycle T when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - req_addr, req_we, req_wdata and req_wstrb are latched at acceptance; later changes are ignored.
- Store (IDLE -> WRITE):
  - Only the lanes with a set strobe bit are issued, in ascending lane order, one per cycle, starting at T+1.
  - No cycles are spent on unset lanes.
  - Each issue cycle: mem_we=1, mem_addr={addr,lane}, mem_wdata=byte[lane].
  - With n set strobes, the last issue is at T+n, then RESP with resp_valid=1 at T+n+1.
  - wstrb=0000: no memory activity, resp_valid=1 at T+1.
- Load (IDLE -> READ_ISSUE -> READ_DRAIN):
  - Lanes 0..3 are issued back-to-back at T+1..T+4 with mem_we=0.
  - The byte for lane k is captured from mem_rdata at the end of cycle T+1+k+RD_LAT into buffer bits [8k+7:8k].
  - After the lane-3 capture, RESP: resp_valid=1, resp_rdata=assembled word, in cycle T+5+RD_LAT (T+7 for RD_LAT=2).
  - Capture is driven by a shift-register pipeline of RD_LAT stages tagging each issued lane, not by state alone.
- RESP:
  - Lasts exactly one cycle, then IDLE.
  - req_ready=0 during RESP and returns to 1 the following cycle, so the earliest next acceptance is the cycle after resp_valid.
- Non-issue cycles: mem_we=0; mem_addr and mem_wdata are driven to 0.
- resp_rdata holds its value until the next response; stores set it to 0.
- Address wrap: the word address is used verbatim; the lane concatenation never carries into the word field. Word address 127, lane 3 gives mem_addr=511.
- req_valid asserted while req_ready=0 is ignored, with no side effects.

Test Plan:
- Store addr=0x05, wdata=0xA1B2C3D4, wstrb=1111 accepted at T -> mem writes (0x014,D4),(0x015,C3),(0x016,B2),(0x017,A1) at T+1..T+4; resp_valid at T+5, resp_rdata=0.
- Load addr=0x05 after the above, RD_LAT=2, byte RAM model -> mem_addr 0x014..0x017 at T+1..T+4, mem_we=0; resp_valid at T+7 with resp_rdata=0xA1B2C3D4.
- Store wstrb=1010, wdata=0x11223344 at addr 0x7F -> only (0x1FD,33),(0x1FF,11) at T+1,T+2; resp at T+3. A following load returns 0x11xx33xx, with unchanged bytes preserved.
- Store wstrb=0000 -> no mem_we pulses; resp_valid at T+1; req_ready=1 at T+2.
- RST asserted at T+2 of a load -> next cycle all outputs at reset values; no resp_valid; a new load is accepted and completes normally.
- Back-to-back req_valid held high for two loads, RD_LAT=1 and RD_LAT=3 builds -> second acceptance is the cycle after the first resp_valid; resp latencies are T+6 and T+8 respectively.
